// File: rtl/mor1kx_wb_arbiter_cappuccino_pkg.sv
// Shared constants for the cappuccino writeback arbiter.
// Defines source indices, the fixed priority order and a one-hot to index helper.
package mor1kx_wb_arbiter_cappuccino_pkg;

  localparam int WB_NUM_SRC = 4;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_LSU = 2'd1;
  localparam logic [1:0] WB_SRC_MUL = 2'd2;
  localparam logic [1:0] WB_SRC_SPR = 2'd3;

  // An upward modulo-4 search starting at LSU yields LSU > MUL > SPR > ALU.
  localparam logic [1:0] WB_FIXED_START = WB_SRC_LSU;

  function automatic logic [1:0] wb_onehot_idx(input logic [WB_NUM_SRC-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mor1kx_wb_arb_sel.sv
// Combinational 4-way selector: masked requests win lowest-index first,
// otherwise requests are searched upward from start, modulo 4. Output is one-hot.
module mor1kx_wb_arb_sel
  import mor1kx_wb_arbiter_cappuccino_pkg::*;
(
  input  logic [WB_NUM_SRC-1:0] req,
  input  logic [WB_NUM_SRC-1:0] mask,
  input  logic [1:0]            start,
  output logic [WB_NUM_SRC-1:0] grant
);

  logic [WB_NUM_SRC-1:0] hi_req;
  logic                  found;
  logic [1:0]            idx;

  assign hi_req = req & mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 2'd0;
    if (|hi_req) begin
      for (int i = 0; i < WB_NUM_SRC; i++) begin
        if (!found && hi_req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < WB_NUM_SRC; k++) begin
        idx = start + 2'(k);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mor1kx_wb_arbiter_cappuccino.sv
// Register-file write port arbiter for ALU/LSU/MUL/SPR results, one grant per cycle.
// Define MOR1KX_WB_ARB_RR_EN to replace fixed priority + starvation with round-robin.
module mor1kx_wb_arbiter_cappuccino
  import mor1kx_wb_arbiter_cappuccino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT         = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [WB_NUM_SRC-1:0]                      src_valid_i,
  output logic [WB_NUM_SRC-1:0]                      src_ready_o,
  input  logic [WB_NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_result_i,
  input  logic [WB_NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0] src_rfd_adr_i,
  input  logic                                       rf_stall_i,
  input  logic                                       flush_i,
  output logic                                       rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]            rf_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]            rf_result_o,
  output logic [1:0]                                 rf_src_o
);

  localparam int DW = OPTION_OPERAND_WIDTH;
  localparam int AW = OPTION_RF_ADDR_WIDTH;

  // Handshake: a source transfers in a cycle where src_valid_i[i] & src_ready_o[i];
  // the source holds valid, result and address stable until that cycle.
  logic [WB_NUM_SRC-1:0]      sel_mask;
  logic [1:0]                 sel_start;
  logic [WB_NUM_SRC-1:0]      sel_grant;
  logic [WB_NUM_SRC-1:0]      grant;
  logic [1:0]                 grant_idx;
  logic [WB_NUM_SRC-1:0][3:0] wait_cnt;
  logic [AW-1:0]              grant_adr;
  logic [DW-1:0]              grant_result;

  mor1kx_wb_arb_sel u_sel (
    .req   (src_valid_i),
    .mask  (sel_mask),
    .start (sel_start),
    .grant (sel_grant)
  );

  assign grant        = (rst || rf_stall_i || flush_i) ? '0 : sel_grant;
  assign src_ready_o  = grant;
  assign grant_idx    = wb_onehot_idx(grant);
  assign grant_adr    = src_rfd_adr_i[grant_idx*AW +: AW];
  assign grant_result = src_result_i[grant_idx*DW +: DW];

`ifdef MOR1KX_WB_ARB_RR_EN
  logic [1:0] rr_ptr;

  assign sel_mask  = '0;
  assign sel_start = rr_ptr;
  assign wait_cnt  = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (|grant) begin
      rr_ptr <= grant_idx + 2'd1;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  assign sel_start = WB_FIXED_START;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      sel_mask[i] = (wait_cnt[i] == LIMIT);
    end
  end

  // Counters still advance while the RF is stalled, so a long stall promotes waiters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < WB_NUM_SRC; i++) begin
        if (flush_i || grant[i] || !src_valid_i[i]) begin
          wait_cnt[i] <= 4'd0;
        end else if (wait_cnt[i] != LIMIT) begin
          wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o     <= 1'b0;
      rf_adr_o    <= '0;
      rf_result_o <= '0;
      rf_src_o    <= 2'd0;
    end else if (flush_i) begin
      rf_we_o <= 1'b0;
    end else if (!rf_stall_i) begin
      if (|grant) begin
        rf_we_o     <= (grant_adr != '0);
        rf_adr_o    <= grant_adr;
        rf_result_o <= grant_result;
        rf_src_o    <= grant_idx;
      end else begin
        rf_we_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_arbiter_cappuccino.sv
// Self-checking bench for mor1kx_wb_arbiter_cappuccino (default and MOR1KX_WB_ARB_RR_EN builds).
module tb_mor1kx_wb_arbiter_cappuccino;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic                  clk;
  logic                  rst;
  logic [3:0]            v;
  logic [3:0]            src_ready_o;
  logic [3:0][DW-1:0]    res;
  logic [3:0][AW-1:0]    adr;
  logic                  stall;
  logic                  flush;
  logic                  rf_we_o;
  logic [AW-1:0]         rf_adr_o;
  logic [DW-1:0]         rf_result_o;
  logic [1:0]            rf_src_o;

  int checks = 0;
  int errors = 0;

  // Model state
  int         m_cnt [4];
  logic [1:0] m_ptr;
  logic       e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_res;
  logic [1:0] e_src;
  logic [3:0] exp_ready;
  logic [3:0] act_ready;
  logic [39:0] exp_q[$];
  logic [39:0] obs;
  logic [39:0] exp_v;

  mor1kx_wb_arbiter_cappuccino #(
    .OPTION_OPERAND_WIDTH (DW),
    .OPTION_RF_ADDR_WIDTH (AW),
    .STARVE_LIMIT         (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid_i   (v),
    .src_ready_o   (src_ready_o),
    .src_result_i  (res),
    .src_rfd_adr_i (adr),
    .rf_stall_i    (stall),
    .flush_i       (flush),
    .rf_we_o       (rf_we_o),
    .rf_adr_o      (rf_adr_o),
    .rf_result_o   (rf_result_o),
    .rf_src_o      (rf_src_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_ptr = 2'd0;
    e_we = 1'b0; e_adr = '0; e_res = '0; e_src = 2'd0;
    exp_q.delete();
  endtask

  // Reference grant: priority list LSU, MUL, SPR, ALU with starved sources first.
  function automatic logic [3:0] model_grant();
    int order [4] = '{1, 2, 3, 0};
    int j;
    if (stall || flush) return 4'b0000;
`ifdef MOR1KX_WB_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      j = (int'(m_ptr) + k) % 4;
      if (v[j]) return 4'(1 << j);
    end
`else
    for (int i = 0; i < 4; i++)
      if (v[i] && m_cnt[i] == LIMIT) return 4'(1 << i);
    for (int k = 0; k < 4; k++) begin
      j = order[k];
      if (v[j]) return 4'(1 << j);
    end
`endif
    return 4'b0000;
  endfunction

  // Driver step: samples ready, advances the model, pushes the expected post-edge outputs.
  task automatic tick();
    logic [3:0] g;
    int gi;
    #1;
    act_ready = src_ready_o;
    g = model_grant();
    exp_ready = g;
    gi = 0;
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    if (flush) begin
      e_we = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
`ifndef MOR1KX_WB_ARB_RR_EN
      for (int i = 0; i < 4; i++) begin
        if (g[i] || !v[i]) m_cnt[i] = 0;
        else if (m_cnt[i] < LIMIT) m_cnt[i] = m_cnt[i] + 1;
      end
`endif
      if (!stall) begin
        if (g != 4'b0000) begin
          e_we  = (adr[gi] != 0);
          e_adr = adr[gi];
          e_res = res[gi];
          e_src = 2'(gi);
          m_ptr = 2'(gi + 1);
        end else begin
          e_we = 1'b0;
        end
      end
    end
    exp_q.push_back({e_we, e_adr, e_res, e_src});
    @(posedge clk);
    #1;
  endtask

  // A granted source presents a fresh result (new data, same or new address).
  task automatic refresh_granted(input bit rand_addr);
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        res[i] = $urandom;
        if (rand_addr) adr[i] = 5'($urandom_range(0, 31));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v = '0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin res[i] = '0; adr[i] = '0; end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (src_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", src_ready_o); end
    checks++;
    if ({rf_we_o, rf_adr_o, rf_result_o, rf_src_o} !== 40'd0) begin
      errors++; $display("FAIL reset_outputs got we=%b adr=%0d res=%h src=%0d want all 0",
                        rf_we_o, rf_adr_o, rf_result_o, rf_src_o);
    end
    rst = 1'b0;
    tick();
    checks++;
    obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
    if (obs !== exp_v || rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_idle got %h want %h", obs, exp_v); end
  endtask

  task automatic test_priority();
    adr[0] = 5'd3; res[0] = 32'h11;
    adr[1] = 5'd4; res[1] = 32'h22;
    v = 4'b0011;
    tick();
    checks++;
    if (act_ready !== 4'b0010) begin errors++; $display("FAIL prio_ready1 got %b want 0010", act_ready); end
    checks++;
    exp_v = exp_q.pop_front();
    if ({rf_we_o, rf_adr_o, rf_result_o, rf_src_o} !== {1'b1, 5'd4, 32'h22, 2'd1} || exp_v[39:0] !== {1'b1, 5'd4, 32'h22, 2'd1}) begin
      errors++; $display("FAIL prio_lsu got we=%b adr=%0d res=%h src=%0d want 1/4/22/1", rf_we_o, rf_adr_o, rf_result_o, rf_src_o);
    end
    v = 4'b0001;
    tick();
    checks++;
    if (act_ready !== 4'b0001) begin errors++; $display("FAIL prio_ready2 got %b want 0001", act_ready); end
    checks++;
    exp_v = exp_q.pop_front();
    if ({rf_we_o, rf_adr_o, rf_result_o, rf_src_o} !== exp_v) begin
      errors++; $display("FAIL prio_alu got adr=%0d res=%h src=%0d want adr=3 res=11 src=0", rf_adr_o, rf_result_o, rf_src_o);
    end
    v = 4'b0000;
    tick();
    checks++;
    obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL prio_idle_hold got %h want %h", obs, exp_v); end
  endtask

  task automatic test_starvation();
    adr[0] = 5'd5; adr[1] = 5'd6;
    v = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (act_ready !== ((k == 4) ? 4'b0001 : 4'b0010)) begin
        errors++; $display("FAIL starve_ready[%0d] got %b want %b", k, act_ready, (k == 4) ? 4'b0001 : 4'b0010);
      end
      checks++;
      obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL starve_out[%0d] got %h want %h", k, obs, exp_v); end
      refresh_granted(1'b0);
    end
    v = 4'b0000;
    tick();
    void'(exp_q.pop_front());
  endtask

  task automatic test_stall();
    adr[1] = 5'd7; res[1] = 32'h33;
    v = 4'b0010; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (act_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0000", k, act_ready); end
      checks++;
      obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL stall_hold[%0d] got %h want %h", k, obs, exp_v); end
    end
    checks++;
    if (dut.wait_cnt[1] !== 4'(m_cnt[1])) begin errors++; $display("FAIL stall_cnt got %0d want %0d", dut.wait_cnt[1], m_cnt[1]); end
    stall = 1'b0;
    tick();
    checks++;
    if (act_ready !== 4'b0010) begin errors++; $display("FAIL stall_release got %b want 0010", act_ready); end
    checks++;
    obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
    if (obs !== exp_v || rf_we_o !== 1'b1 || rf_adr_o !== 5'd7) begin errors++; $display("FAIL stall_grant got %h want %h", obs, exp_v); end
    v = 4'b0000;
  endtask

  task automatic test_flush_r0();
    adr[2] = 5'd9; res[2] = 32'h44;
    adr[3] = 5'd0; res[3] = 32'h55;
    v = 4'b1100;
    tick();                 // SPR waits one cycle while MUL wins
    refresh_granted(1'b0);
    void'(exp_q.pop_front());
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if (act_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", act_ready); end
    checks++;
    if (rf_we_o !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", rf_we_o); end
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.wait_cnt[i] !== 4'd0) begin errors++; $display("FAIL flush_cnt[%0d] got %0d want 0", i, dut.wait_cnt[i]); end
    end
    flush = 1'b0; stall = 1'b0;
    tick();
    refresh_granted(1'b0);
    checks++;
    if (act_ready !== 4'b0100) begin errors++; $display("FAIL flush_after got %b want 0100", act_ready); end
    void'(exp_q.pop_front());
    v = 4'b1000;
    tick();
    checks++;
    if (act_ready !== 4'b1000) begin errors++; $display("FAIL r0_ready got %b want 1000", act_ready); end
    checks++;
    obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
    if (obs !== exp_v || rf_we_o !== 1'b0 || rf_src_o !== 2'd3) begin errors++; $display("FAIL r0_write got %h want %h", obs, exp_v); end
    v = 4'b0000;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", k, act_ready, exp_ready); end
      checks++;
      obs = {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}; exp_v = exp_q.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL rand_out[%0d] got %h want %h", k, obs, exp_v); end
      refresh_granted(1'b1);
      for (int i = 0; i < 4; i++) begin
        if (exp_ready[i] || !v[i]) v[i] = ($urandom_range(0, 2) != 0);
      end
    end
    v = 4'b0000; stall = 1'b0; flush = 1'b0;
  endtask

`ifdef MOR1KX_WB_ARB_RR_EN
  task automatic test_rr();
    for (int i = 0; i < 4; i++) adr[i] = 5'(i + 10);
    v = 4'b1111;
    tick(); void'(exp_q.pop_front());   // align the pointer from whatever state preceded
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, act_ready, exp_ready); end
      void'(exp_q.pop_front());
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rf_we_o, rf_adr_o, rf_result_o, rf_src_o} !== 40'd0) begin errors++; $display("FAIL rr_async_reset got %h want 0", {rf_we_o, rf_adr_o, rf_result_o, rf_src_o}); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    tick();
    checks++;
    if (act_ready !== 4'b0001) begin errors++; $display("FAIL rr_restart got %b want 0001", act_ready); end
    void'(exp_q.pop_front());
    v = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
`ifdef MOR1KX_WB_ARB_RR_EN
    test_rr();
`else
    test_priority();
    test_starvation();
    test_stall();
    test_flush_r0();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mor1kx_wb_arbiter_cappuccino.md
Name:
mor1kx_wb_arbiter_cappuccino

Overview:
- Schedules the single register-file write port between four result producers: ALU, LSU, MUL and SPR.
- Each producer offers a result and a destination register through a valid/ready handshake.
- The arbiter grants one producer per cycle and registers the winning result, address and write enable towards the RF.
- It sits between the execute/control stages and the RF. Producers with different latencies can finish in the same cycle without colliding on the write port.

Parameters:
- OPTION_OPERAND_WIDTH, 32: result data width.
- OPTION_RF_ADDR_WIDTH, 5: RF address width.
- STARVE_LIMIT, 4: number of consecutive denied cycles after which a waiting source is promoted; legal range 1..15.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- src_valid_i  in  4  per-source result valid; index 0=ALU, 1=LSU, 2=MUL, 3=SPR.
- src_ready_o  out  4  per-source grant; the transfer occurs when valid&ready.
- src_result_i  in  4*OPTION_OPERAND_WIDTH  packed results; slice i belongs to source i.
- src_rfd_adr_i  in  4*OPTION_RF_ADDR_WIDTH  packed destination addresses.
- rf_stall_i  in  1  RF port busy: hold outputs, grant nothing.
- flush_i  in  1  pipeline flush: drop all pending requests.
- rf_we_o  out  1  registered RF write enable.
- rf_adr_o  out  OPTION_RF_ADDR_WIDTH  registered RF write address.
- rf_result_o  out  OPTION_OPERAND_WIDTH  registered RF write data.
- rf_src_o  out  2  registered index of the source that produced the current write.

Behaviour:
- Reset (asynchronous, active-high): rf_we_o=0, rf_adr_o=0, rf_result_o=0, rf_src_o=0, all wait counters=0, RR pointer=0. src_ready_o is combinational and is 0 while rst is high.
- Grant logic is combinational:
  - At most one bit of src_ready_o is high.
  - No ready bit is asserted to a source whose valid is low.
  - All ready bits are 0 when rf_stall_i or flush_i is high.
- Default priority is fixed: LSU > MUL > SPR > ALU.
- Starvation override: per-source wait counter, 4 bits.
  - Increments when valid and not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on grant, when valid is low, or on flush_i.
  - Any source whose counter equals STARVE_LIMIT beats all non-starved sources. Among several starved sources, the lowest index wins.
- Latency is 1 cycle: a grant in cycle N updates rf_adr_o, rf_result_o and rf_src_o at edge N+1, with rf_we_o=1.
- When no grant occurs, rf_we_o=0 at the next edge. Address, data and source outputs hold their previous values.
- r0 suppression: a granted transfer with destination address 0 is consumed (ready=1) but produces rf_we_o=0. Address, data and source still update.
- rf_stall_i=1: all output registers hold, including rf_we_o. Wait counters keep incrementing for valid sources.
- flush_i=1: no grants; rf_we_o=0 at the next edge; counters clear. flush_i has priority over rf_stall_i.
- Sources hold valid, result and address stable until granted. The arbiter does not buffer requests internally.

Optional Feature:
- Macro: MOR1KX_WB_ARB_RR_EN.
- Defined:
  - Fixed priority and starvation counters are removed; counters are tied to 0.
  - Round-robin replaces them. A 2-bit pointer marks the highest-priority source and searches upward, modulo 4.
  - After each grant, the pointer moves to (granted index + 1) mod 4. It holds on stall, flush or no grant, and resets to 0.
- Undefined: fixed priority plus starvation override, as described above.

Decomposition:
- Shared package/defines file holds:
  - source index constants WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MUL=2, WB_SRC_SPR=3;
  - WB_NUM_SRC=4;
  - the fixed priority order.
- One natural sub-module, mor1kx_wb_arb_sel: a combinational 4-way selector that takes request and priority-mask vectors and returns a one-hot grant. It is shared by the fixed and RR variants.
- Counters, pointer and output registers stay in the top module.

Test Plan:
- After reset, no valids -> rf_we_o=0, src_ready_o=4'b0000, all outputs 0.
- ALU and LSU valid in the same cycle, ALU addr 3 data 0x11, LSU addr 4 data 0x22 -> LSU granted first: next cycle rf_we_o=1, rf_adr_o=4, rf_result_o=0x22, rf_src_o=1. ALU granted one cycle later: rf_adr_o=3, rf_result_o=0x11.
- Starvation: ALU held valid while LSU stays valid continuously with STARVE_LIMIT=4 -> LSU wins 4 cycles, ALU is granted in the 5th cycle, then LSU resumes.
- Stall: LSU valid with rf_stall_i=1 for 3 cycles -> src_ready_o=0 throughout, outputs frozen; grant follows the first cycle after stall drops.
- flush_i pulsed with MUL and SPR valid -> no ready that cycle, rf_we_o=0 next cycle, counters read 0. A SPR transfer to address 0 -> ready=1 and rf_we_o=0.
- With RR_EN, all four sources valid continuously -> grant order 0,1,2,3,0; assert rst mid-sequence -> all outputs 0 immediately, pointer restarts at 0.
